// File: rtl/chose_nto1_rr.sv
// N-to-1 valid/ready channel selector with manual or round-robin grant and one registered output stage.
// Optional CHOSE_CNT_EN adds a 16-bit output-transfer counter port xfer_cnt.
module chose_nto1_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
`ifdef CHOSE_CNT_EN
    ,
    output logic [15:0]    xfer_cnt
`endif
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    logic          load_en_s;
    logic          grant_vld_s;
    logic [SW-1:0] grant_idx_s;
    logic [W-1:0]  grant_data_s;
    logic          in_xfer_s;
    logic [N-1:0]  rot_valid_s;

    // Valid vector rotated so bit k is channel (rr_ptr + k) mod N.
    always_comb begin
        rot_valid_s = N'({in_valid, in_valid} >> rr_ptr_q);
    end

    // Grant selection; the reverse loop lets the earliest candidate win.
    always_comb begin
        logic [SW:0] cand_v;
        grant_vld_s = 1'b0;
        grant_idx_s = {SW{1'b0}};
        cand_v      = {(SW+1){1'b0}};
        if (mode == 1'b0) begin
            for (int i = 0; i < N; i++) begin
                if ((sel == SW'(i)) && in_valid[i]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = SW'(i);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (rot_valid_s[k]) begin
                    cand_v = {1'b0, rr_ptr_q} + (SW+1)'(k);
                    if (cand_v >= (SW+1)'(N)) begin
                        cand_v = cand_v - (SW+1)'(N);
                    end else begin
                        cand_v = cand_v;
                    end
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_v[SW-1:0];
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        grant_data_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (grant_idx_s == SW'(i)) begin
                grant_data_s = in_data[i*W +: W];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
    end

    // Handshake: accept only when the output register is empty or draining.
    always_comb begin
        load_en_s = !out_valid_q || out_ready;
        in_xfer_s = grant_vld_s && load_en_s;
        in_ready  = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (rst_n && in_xfer_s && (grant_idx_s == SW'(i))) begin
                in_ready[i] = 1'b1;
            end else begin
                in_ready[i] = 1'b0;
            end
        end
    end

    // Next state of the output stage and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (in_xfer_s) begin
            out_data_d  = grant_data_s;
            out_ch_d    = grant_idx_s;
            out_valid_d = 1'b1;
            if (mode == 1'b1) begin
                if (grant_idx_s == SW'(N - 1)) begin
                    rr_ptr_d = {SW{1'b0}};
                end else begin
                    rr_ptr_d = grant_idx_s + SW'(1);
                end
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= {W{1'b0}};
            out_ch_q    <= {SW{1'b0}};
            out_valid_q <= 1'b0;
            rr_ptr_q    <= {SW{1'b0}};
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

`ifdef CHOSE_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    // Count output transfers, wrapping naturally at 16 bits.
    always_comb begin
        if (out_valid_q && out_ready) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt_q <= 16'd0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_chose_nto1_rr.sv
// Self-checking bench for chose_nto1_rr (N=4, W=8): behavioural model plus directed literal checks and random traffic.
module tb_chose_nto1_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic          mode;
    logic [1:0]    sel;
    logic [W-1:0]  out_data;
    logic [1:0]    out_ch;
    logic          out_valid;
    logic          out_ready;
`ifdef CHOSE_CNT_EN
    logic [15:0]   xfer_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    chose_nto1_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CHOSE_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the word held by the output register and the search start.
    logic        m_valid = 1'b0;
    int          m_data  = 0;
    int          m_ch    = 0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;
    int          m_grant;

    function automatic int model_grant(input logic md, input int s, input logic [N-1:0] v, input int ptr);
        if (md == 1'b0) begin
            if (s < N && v[s]) return s;
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        if (!rst_n || m_grant < 0 || !(!m_valid || out_ready)) return 4'b0000;
        return 4'(1 << m_grant);
    endfunction

    always_comb m_grant = model_grant(mode, int'(sel), in_valid, m_ptr);

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 0;
            m_ch    <= 0;
            m_ptr   <= 0;
            m_cnt   <= 0;
        end else begin
            if (m_valid && out_ready) m_cnt <= (m_cnt + 1) % 65536;
            if (m_grant >= 0 && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_data  <= int'(in_data[m_grant*W +: W]);
                m_ch    <= m_grant;
                if (mode) m_ptr <= (m_grant + 1) % N;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare DUT against the model every falling edge.
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(model_ready()));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), m_data);
        check("out_ch", 32'(out_ch), m_ch);
`ifdef CHOSE_CNT_EN
        check("xfer_cnt", 32'(xfer_cnt), m_cnt);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int rr_seq[6]  = '{0, 1, 2, 3, 0, 1};
    int sp_seq[4]  = '{1, 3, 1, 3};

    initial begin
        rst_n     = 1'b0;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid  = 4'b1111;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;

        // Reset with all inputs valid.
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        #1 check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("first_rr_grant", 32'(in_ready), 32'b0001);

        // Manual select of channel 2.
        mode = 1'b0;
        sel  = 2'd2;
        #1 check("man_in_ready", 32'(in_ready), 32'b0100);
        tick();
        check("man_out_data", 32'(out_data), 32'h33);
        check("man_out_ch", 32'(out_ch), 32'd2);
        check("man_out_valid", 32'(out_valid), 32'd1);
        in_valid = 4'b1011;
        #1 check("man_no_grant", 32'(in_ready), 32'd0);
        tick();
        check("man_drained", 32'(out_valid), 32'd0);
        check("man_data_held", 32'(out_data), 32'h33);

        // Round-robin with everything valid: no bubbles.
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_out_ch", 32'(out_ch), 32'(rr_seq[i]));
            check("rr_out_valid", 32'(out_valid), 32'd1);
        end

        // Reset mid-transfer with the pointer at 2.
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1 check("midrst_grant", 32'(in_ready), 32'b0001);

        // Sparse round-robin.
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sparse_out_ch", 32'(out_ch), 32'(sp_seq[i]));
        end

        // Stall after the first word from channel 0.
        in_valid = 4'b0000;
        tick();
        in_valid = 4'b1111;
        tick();
        check("stall_first_ch", 32'(out_ch), 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("stall_data", 32'(out_data), 32'h11);
            check("stall_ch", 32'(out_ch), 32'd0);
        end
        out_ready = 1'b1;
        #1 check("unstall_ready", 32'(in_ready), 32'b0010);
        tick();
        check("unstall_ch", 32'(out_ch), 32'd1);
        check("unstall_data", 32'(out_data), 32'h22);

        // Random traffic checked by the model.
        for (int i = 0; i < 400; i++) begin
            in_data   = $urandom;
            in_valid  = 4'($urandom);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            tick();
        end
        rst_n = 1'b1;

`ifdef CHOSE_CNT_EN
        // Transfer counter: five transfers, then wrap.
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("cnt_five", 32'(xfer_cnt), 32'd5);
        for (int i = 0; i < 65531; i++) tick();
        check("cnt_wrap", 32'(xfer_cnt), 32'd0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
